// File: rtl/channel_mixer.sv
// channel_mixer: three-channel tone/noise gate, volume LUT and summing pipeline.
// Define CHANNEL_MIXER_PWM_OUT_EN to add a PWM DAC output driven by master_out.
module channel_mixer #(
   parameter int CHANNEL_OUTPUT_BITS = 8,
   parameter int MASTER_OUTPUT_BITS  = 10
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [2:0]                     tone,
   input  logic                           noise,
   input  logic [2:0]                     tone_disable,
   input  logic [2:0]                     noise_disable,
   input  logic [4:0]                     amplitude_a,
   input  logic [4:0]                     amplitude_b,
   input  logic [4:0]                     amplitude_c,
   input  logic [3:0]                     envelope,
   output logic [CHANNEL_OUTPUT_BITS-1:0] channel_a,
   output logic [CHANNEL_OUTPUT_BITS-1:0] channel_b,
   output logic [CHANNEL_OUTPUT_BITS-1:0] channel_c,
`ifdef CHANNEL_MIXER_PWM_OUT_EN
   output logic                           pwm_out,
`endif
   output logic [MASTER_OUTPUT_BITS-1:0]  master_out
);
   localparam int CW = CHANNEL_OUTPUT_BITS;
   localparam int MW = MASTER_OUTPUT_BITS;
   localparam logic [7:0] LUT [16] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
                                       8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd181, 8'd255};

   // MSB-align the 8-bit table entry to the channel width
   function automatic logic [CW-1:0] scale(input logic [3:0] l);
      return CW'({LUT[l], {CW{1'b0}}} >> 8);
   endfunction

   logic [4:0] amp [3];
   logic [2:0] gate_q;
   logic [3:0] level_q [3];

   assign amp[0] = amplitude_a;
   assign amp[1] = amplitude_b;
   assign amp[2] = amplitude_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gate_q     <= '0;
         level_q[0] <= '0;
         level_q[1] <= '0;
         level_q[2] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            gate_q[i]  <= (tone[i] | tone_disable[i]) & (noise | noise_disable[i]);
            level_q[i] <= amp[i][4] ? envelope : amp[i][3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         channel_a  <= '0;
         channel_b  <= '0;
         channel_c  <= '0;
         master_out <= '0;
      end else begin
         channel_a  <= gate_q[0] ? scale(level_q[0]) : '0;
         channel_b  <= gate_q[1] ? scale(level_q[1]) : '0;
         channel_c  <= gate_q[2] ? scale(level_q[2]) : '0;
         master_out <= MW'(channel_a) + MW'(channel_b) + MW'(channel_c);
      end
   end

`ifdef CHANNEL_MIXER_PWM_OUT_EN
   logic [MW-1:0] cnt;
   logic [MW-1:0] duty;

   // duty is only sampled at frame start so each frame has a single width
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         duty    <= '0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= cnt + 1'b1;
         duty    <= (cnt == '0) ? master_out : duty;
         pwm_out <= cnt < duty;
      end
   end
`endif
endmodule

// File: tb/tb_channel_mixer.sv
// tb_channel_mixer: randomized scoreboard bench for channel_mixer against a level/gate model.
module tb_channel_mixer;
   logic       clk = 0;
   logic       reset_n = 0;
   logic [2:0] tone = 0, tone_disable = 0, noise_disable = 0;
   logic       noise = 0;
   logic [4:0] amplitude_a = 0, amplitude_b = 0, amplitude_c = 0;
   logic [3:0] envelope = 0;
   logic [7:0] channel_a, channel_b, channel_c;
   logic [9:0] master_out;
`ifdef CHANNEL_MIXER_PWM_OUT_EN
   logic       pwm_out;
`endif

   channel_mixer dut (
      .clk(clk), .reset_n(reset_n), .tone(tone), .noise(noise),
      .tone_disable(tone_disable), .noise_disable(noise_disable),
      .amplitude_a(amplitude_a), .amplitude_b(amplitude_b), .amplitude_c(amplitude_c),
      .envelope(envelope), .channel_a(channel_a), .channel_b(channel_b), .channel_c(channel_c),
`ifdef CHANNEL_MIXER_PWM_OUT_EN
      .pwm_out(pwm_out),
`endif
      .master_out(master_out)
   );

   always #5 clk = ~clk;

   typedef struct {int a; int b; int c;} exp_t;
   exp_t qch[$];
   int   qm[$];
   int   n_checks = 0, n_fail = 0, edge_n = 0;
   bit   active = 1;
   int   vol [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 181, 255};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // a channel is heard when every enabled source is high
   function automatic int model(input bit t, input bit td, input bit nd, input logic [4:0] amp);
      int lvl;
      lvl = amp[4] ? int'(envelope) : int'(amp[3:0]);
      if ((td || t) && (nd || noise)) return vol[lvl];
      return 0;
   endfunction

   task automatic drive(input logic [2:0] t, input logic n, input logic [2:0] td, input logic [2:0] nd,
                        input logic [4:0] aa, input logic [4:0] ab, input logic [4:0] ac,
                        input logic [3:0] env, input bit push);
      exp_t e;
      tone = t; noise = n; tone_disable = td; noise_disable = nd;
      amplitude_a = aa; amplitude_b = ab; amplitude_c = ac; envelope = env;
      e.a = model(t[0], td[0], nd[0], aa);
      e.b = model(t[1], td[1], nd[1], ab);
      e.c = model(t[2], td[2], nd[2], ac);
      if (push) begin
         qch.push_back(e);
         qm.push_back(e.a + e.b + e.c);
      end
      @(negedge clk);
   endtask

   task automatic drive_rand(input bit push);
      drive(3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom), 4'($urandom), push);
   endtask

   task automatic check_zero(input string name);
      check({name, "_a"}, channel_a, 0);
      check({name, "_b"}, channel_b, 0);
      check({name, "_c"}, channel_c, 0);
      check({name, "_m"}, master_out, 0);
   endtask

   task automatic do_reset();
      reset_n = 0;
      #1;
      check_zero("reset_async");
`ifdef CHANNEL_MIXER_PWM_OUT_EN
      check("reset_pwm", pwm_out, 0);
`endif
      qch.delete();
      qm.delete();
      @(negedge clk);
      repeat (3) begin
         drive_rand(0);
         check_zero("reset_hold");
      end
      edge_n = 0;
      reset_n = 1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n) begin
            edge_n++;
            if (edge_n < 2) begin
               check("pre_a", channel_a, 0);
               check("pre_b", channel_b, 0);
               check("pre_c", channel_c, 0);
            end else if (qch.size() > 0) begin
               e = qch.pop_front();
               check("chan_a", channel_a, e.a);
               check("chan_b", channel_b, e.b);
               check("chan_c", channel_c, e.c);
            end else if (active) check("chan_queue_empty", 1, 0);
            if (edge_n < 3) check("pre_master", master_out, 0);
            else if (qm.size() > 0) check("master", master_out, qm.pop_front());
            else if (active) check("master_queue_empty", 1, 0);
         end
      end
   end

   initial begin
      int highs;
      @(negedge clk);
      do_reset();
      repeat (6) drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd15, 5'd15, 5'd15, 4'd0, 1);
      check("dc_a", channel_a, 255);
      check("dc_master", master_out, 765);
      for (int i = 0; i < 10; i++) drive({2'b00, 1'(i)}, 1'b0, 3'd0, 3'd7, 5'd8, 5'd0, 5'd0, 4'd0, 1);
      for (int i = 0; i < 16; i++) drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd0, 5'h10, 5'd0, 4'(i), 1);
      for (int i = 0; i < 16; i++) drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd0, 5'h00, 5'd0, 4'(i), 1);
      repeat (3) drive(3'b100, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd15, 4'd0, 1);
      check("noise_low_c", channel_c, 0);
      repeat (3) drive(3'b100, 1'b1, 3'd0, 3'd0, 5'd0, 5'd0, 5'd15, 4'd0, 1);
      check("noise_high_c", channel_c, 255);
      repeat (300) drive_rand(1);
      do_reset();
      repeat (200) drive_rand(1);
`ifdef CHANNEL_MIXER_PWM_OUT_EN
      do_reset();
      highs = 0;
      for (int j = 1; j <= 2200; j++) begin
         drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd15, 5'd15, 5'd15, 4'd0, 1);
         if (j >= 1100 && j < 2124) highs += int'(pwm_out);
      end
      check("pwm_highs_765", highs, 765);
      repeat (100) drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd15, 5'd15, 5'd15, 4'd0, 1);
      do_reset();
      highs = 0;
      for (int j = 1; j <= 1025; j++) begin
         drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd15, 5'd15, 5'd15, 4'd0, 1);
         highs += int'(pwm_out);
      end
      check("pwm_first_frame", highs, 0);
      drive(3'd0, 1'b0, 3'd7, 3'd7, 5'd15, 5'd15, 5'd15, 4'd0, 1);
      check("pwm_restart", pwm_out, 1);
`else
      highs = 0;
      check("no_pwm_highs", highs, 0);
`endif
      active = 0;
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
